// File: rtl/clk_freq_meter.sv
// Measures period and high time of a slow, asynchronous signal in clock_in cycles,
// and flags loss of the signal when no rising edge arrives within TIMEOUT cycles.
module clk_freq_meter #(
  parameter int                   CNT_WIDTH = 32,
  parameter logic [CNT_WIDTH-1:0] TIMEOUT   = CNT_WIDTH'(200000000)
) (
  input  logic                 clock_in,
  input  logic                 reset,
  input  logic                 signal_in,
  output logic [CNT_WIDTH-1:0] period_out,
  output logic [CNT_WIDTH-1:0] high_out,
  output logic                 meas_valid,
  output logic                 timeout,
  output logic                 level_out
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    STALE   = 2'd2
  } state_e;

  localparam logic [CNT_WIDTH-1:0] TO_LAST = TIMEOUT - CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] ONE     = CNT_WIDTH'(1);

  state_e               state_q, state_d;
  logic                 s1_q, s2_q, d_q;
  logic [CNT_WIDTH-1:0] per_cnt_q, per_cnt_d;
  logic [CNT_WIDTH-1:0] hi_cnt_q, hi_cnt_d;
  logic [CNT_WIDTH-1:0] period_q, period_d;
  logic [CNT_WIDTH-1:0] high_q, high_d;
  logic                 valid_q, valid_d;
  logic                 timeout_q, timeout_d;
  logic                 rise;
  logic                 per_hit;

  // Two-flop synchronizer plus one history flop for edge detection.
  always_ff @(posedge clock_in) begin
    if (reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      d_q  <= 1'b0;
    end else begin
      s1_q <= signal_in;
      s2_q <= s1_q;
      d_q  <= s2_q;
    end
  end

  assign rise    = s2_q & ~d_q;
  assign per_hit = (per_cnt_q == TO_LAST);

  always_ff @(posedge clock_in) begin
    if (reset) begin
      state_q   <= IDLE;
      per_cnt_q <= '0;
      hi_cnt_q  <= '0;
      period_q  <= '0;
      high_q    <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      per_cnt_q <= per_cnt_d;
      hi_cnt_q  <= hi_cnt_d;
      period_q  <= period_d;
      high_q    <= high_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    per_cnt_d = per_cnt_q;
    hi_cnt_d  = hi_cnt_q;
    period_d  = period_q;
    high_d    = high_q;
    valid_d   = 1'b0;
    timeout_d = timeout_q;

    // Counters freeze in STALE, which also keeps them from ever wrapping.
    if (rise) begin
      per_cnt_d = ONE;
      hi_cnt_d  = ONE;
    end else if (state_q != STALE) begin
      per_cnt_d = per_cnt_q + ONE;
      hi_cnt_d  = hi_cnt_q + CNT_WIDTH'(s2_q);
    end

    unique case (state_q)
      IDLE: begin
        if (rise) begin
          state_d = MEASURE;
        end else if (per_hit) begin
          state_d   = STALE;
          timeout_d = 1'b1;
          period_d  = '0;
          high_d    = '0;
        end
      end
      MEASURE: begin
        if (rise) begin
          period_d = per_cnt_q;
          high_d   = hi_cnt_q;
          valid_d  = 1'b1;
        end else if (per_hit) begin
          state_d   = STALE;
          timeout_d = 1'b1;
          period_d  = '0;
          high_d    = '0;
        end
      end
      STALE: begin
        // A returning edge is only a new reference; no measurement yet.
        if (rise) begin
          state_d   = MEASURE;
          timeout_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign period_out = period_q;
  assign high_out   = high_q;
  assign meas_valid = valid_q;
  assign timeout    = timeout_q;
  assign level_out  = s2_q;

endmodule

// File: tb/tb_clk_freq_meter.sv
// Bench for clk_freq_meter: directed and random waveforms compared every cycle
// against an edge-list reference model of the measurement rules.
module tb_clk_freq_meter;
  localparam int CW  = 32;
  localparam int TO  = 1000;
  localparam int MAXC = 65536;

  logic          clock_in = 1'b0;
  logic          reset;
  logic          signal_in;
  logic [CW-1:0] period_out;
  logic [CW-1:0] high_out;
  logic          meas_valid;
  logic          timeout;
  logic          level_out;

  clk_freq_meter #(
    .CNT_WIDTH(CW),
    .TIMEOUT  (CW'(TO))
  ) dut (
    .clock_in  (clock_in),
    .reset     (reset),
    .signal_in (signal_in),
    .period_out(period_out),
    .high_out  (high_out),
    .meas_valid(meas_valid),
    .timeout   (timeout),
    .level_out (level_out)
  );

  always #5 clock_in = ~clock_in;

  int checks   = 0;
  int failures = 0;
  int pulses   = 0;

  // Reference model state: cycle index, synchronizer delay line, s2 history,
  // cycle of the current reference edge (or reset), and measurement status.
  int     e = 0;
  bit     m_s1, m_s2, m_d;
  bit     s2hist [MAXC];
  int     ref_cyc;
  bit     have_ref, stale;
  longint exp_per, exp_hi;
  bit     exp_val, exp_to, exp_lvl;
  bit     armed = 1'b0;

  task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s @cycle %0d: got %0d expected %0d", tag, e, obs, exp);
    end
  endtask

  // Expected outputs after the coming clock edge, given that edge's inputs.
  task automatic model_edge(input bit r, input bit s);
    bit     rise;
    longint h;
    exp_val = 1'b0;
    if (r) begin
      m_s1 = 0; m_s2 = 0; m_d = 0;
      exp_per = 0; exp_hi = 0; exp_to = 0;
      have_ref = 0; stale = 0;
      ref_cyc = e + 1;
    end else begin
      rise = m_s2 && !m_d;
      if (rise) begin
        if (have_ref && !stale) begin
          exp_val = 1'b1;
          exp_per = e - ref_cyc;
          h = 0;
          for (int k = ref_cyc; k < e; k++) h += s2hist[k];
          exp_hi = h;
        end
        stale = 0; exp_to = 0; have_ref = 1; ref_cyc = e;
      end else if (!stale && (e - ref_cyc) == TO - 1) begin
        stale = 1; exp_to = 1; exp_per = 0; exp_hi = 0;
      end
      m_d = m_s2; m_s2 = m_s1; m_s1 = s;
    end
    exp_lvl = m_s2;
    e++;
    if (e < MAXC) s2hist[e] = m_s2;
  endtask

  task automatic step(input bit r, input bit s);
    @(negedge clock_in);
    if (armed) begin
      chk_eq("meas_valid", meas_valid, exp_val);
      chk_eq("timeout", timeout, exp_to);
      chk_eq("level_out", level_out, exp_lvl);
      chk_eq("period_out", period_out, exp_per);
      chk_eq("high_out", high_out, exp_hi);
      if (meas_valid === 1'b1) pulses++;
    end
    reset     = r;
    signal_in = s;
    model_edge(r, s);
    armed = 1'b1;
  endtask

  task automatic run_wave(input int hi, input int lo, input int periods);
    for (int p = 0; p < periods; p++) begin
      for (int i = 0; i < hi; i++) step(1'b0, 1'b1);
      for (int i = 0; i < lo; i++) step(1'b0, 1'b0);
    end
  endtask

  task automatic hold(input bit lvl, input int n);
    for (int i = 0; i < n; i++) step(1'b0, lvl);
  endtask

  task automatic do_reset(input bit lvl, input int n);
    for (int i = 0; i < n; i++) step(1'b1, lvl);
  endtask

  initial begin
    int hi, lo, p0;
    reset     = 1'b1;
    signal_in = 1'b0;

    // 50/50 divider output, period 100.
    do_reset(1'b0, 3);
    p0 = pulses;
    run_wave(50, 50, 5);
    chk_eq("div100_period", period_out, 100);
    chk_eq("div100_high", high_out, 50);
    chk_eq("div100_pulses", pulses - p0, 4);

    // Asymmetric 3 high / 7 low.
    p0 = pulses;
    run_wave(3, 7, 6);
    chk_eq("asym_period", period_out, 10);
    chk_eq("asym_high", high_out, 3);
    chk_eq("asym_pulses", pulses - p0, 6);

    // Loss of signal, then recovery.
    hold(1'b0, 1100);
    chk_eq("lost_timeout", timeout, 1);
    chk_eq("lost_period", period_out, 0);
    chk_eq("lost_high", high_out, 0);
    p0 = pulses;
    run_wave(20, 30, 4);
    chk_eq("recover_timeout", timeout, 0);
    chk_eq("recover_period", period_out, 50);
    chk_eq("recover_pulses", pulses - p0, 3);

    // Longest period that still completes, then one that times out.
    run_wave(400, TO - 1 - 400, 3);
    chk_eq("maxper_period", period_out, TO - 1);
    chk_eq("maxper_timeout", timeout, 0);
    run_wave(400, TO - 400, 2);

    // One-cycle reset in the middle of a high phase.
    run_wave(50, 50, 2);
    hold(1'b1, 20);
    do_reset(1'b1, 1);
    p0 = pulses;
    hold(1'b1, 30);
    run_wave(50, 50, 3);
    chk_eq("midrst_pulses", pulses - p0, 2);
    chk_eq("midrst_period", period_out, 100);

    // Constant input from reset: low, then high.
    do_reset(1'b0, 2);
    p0 = pulses;
    hold(1'b0, 1100);
    chk_eq("const0_timeout", timeout, 1);
    chk_eq("const0_pulses", pulses - p0, 0);
    do_reset(1'b1, 2);
    p0 = pulses;
    hold(1'b1, 1100);
    chk_eq("const1_timeout", timeout, 1);
    chk_eq("const1_pulses", pulses - p0, 0);

    // Random phases with occasional resets and signal dropouts.
    for (int it = 0; it < 60; it++) begin
      if ($urandom_range(14, 0) == 0) do_reset(1'($urandom_range(1, 0)), 1);
      if ($urandom_range(19, 0) == 0) hold(1'b0, $urandom_range(1100, 900));
      hi = $urandom_range(60, 2);
      lo = $urandom_range(60, 2);
      run_wave(hi, lo, $urandom_range(3, 1));
    end
    hold(1'b0, 5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
